// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// delay-LFSR polynomial and seed, and the LFSR step function.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/dmem_lfsr16.sv
// 16-bit Galois LFSR that advances one step whenever step is high.
// Used to draw the extra response delay of the memory responder.
module dmem_lfsr16
    import dmem_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    // Hold the seed in reset, otherwise advance on request.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with a fixed accept-to-response
// latency and byte-lane write merge. Define DMEM_RAND_DELAY_EN to add a
// pseudo-random 0..3 cycle extra delay per accepted request.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1,
    parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        write_finish
);

    localparam int WORDS = 2 ** DEPTH_LOG2;

    state_t                  state, state_nxt;
    logic [4:0]              cnt, cnt_nxt, cnt_load;
    logic [1:0]              extra;
    logic                    accept;

    logic                    req_we;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [3:0]              req_wmask;
    logic [31:0]             req_wdata;

    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    rd_we;
    logic [31:0]             mem [WORDS];

    // Address bits outside the word index alias onto the same word.
    logic                    unused_addr;
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

    assign accept   = (state == IDLE) && en;
    assign cnt_load = 5'(LATENCY - 1) + {3'b000, extra};

`ifdef DMEM_RAND_DELAY_EN
    logic [15:0] lfsr_value;
    logic        unused_lfsr;

    dmem_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (accept),
        .value (lfsr_value)
    );

    assign extra       = lfsr_value[1:0];
    assign unused_lfsr = ^lfsr_value[15:2];
`else
    localparam logic [15:0] unused_seed = LFSR_SEED;
    assign extra = 2'd0;
`endif

    // In IDLE the request still sits on the inputs; afterwards use the latched copy.
    assign rd_idx = (state == IDLE) ? addr[DEPTH_LOG2+1:2] : req_idx;
    assign rd_we  = (state == IDLE) ? we : req_we;

    // Next-state and delay-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (en) begin
                    cnt_nxt   = cnt_load;
                    state_nxt = (cnt_load == 5'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!en) begin
                    // Initiator withdrew the request: drop it silently.
                    state_nxt = IDLE;
                    cnt_nxt   = 5'd0;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_we    <= we;
            req_idx   <= addr[DEPTH_LOG2+1:2];
            req_wmask <= wmask;
            req_wdata <= wdata;
        end
    end

    // Read data is sampled on the edge entering RESP and held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 32'h0;
        end else if (state_nxt == RESP && !rd_we) begin
            rdata <= mem[rd_idx];
        end
    end

    // Writes commit on the edge ending RESP, only while the initiator still holds en.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && req_we && en) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wmask[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata_valid  = (state == RESP) && !req_we;
    assign write_finish = (state == RESP) && req_we;

endmodule
